// File: rtl/sdram_ch1_arbiter.sv
// sdram_ch1_arbiter: round-robin sharing of SDRAM channel 1 between three N64 clients, with watchdog
module sdram_ch1_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4095
) (
  input  logic                      clk1x,
  input  logic                      reset,
  input  logic [2:0]                req_ena,
  input  logic [2:0]                req_rnw,
  input  logic [3*ADDR_W-1:0]       req_addr,
  input  logic [3*(DATA_W/8)-1:0]   req_be,
  input  logic [3*DATA_W-1:0]       req_dataWrite,
  output logic [2:0]                req_done,
  output logic [DATA_W-1:0]         req_dataRead,
  output logic                      sdram_ena,
  output logic                      sdram_rnw,
  output logic [ADDR_W-1:0]         sdram_Adr,
  output logic [DATA_W/8-1:0]       sdram_be,
  output logic [DATA_W-1:0]         sdram_dataWrite,
  input  logic                      sdram_done,
  input  logic [DATA_W-1:0]         sdram_dataRead,
  output logic                      busy,
  output logic [1:0]                grant,
  output logic                      timeout_error
);
  localparam int BE_W = DATA_W / 8;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [1:0] last_grant, first, second, sel;
  logic [CW-1:0] cnt;
  logic expire, start, finish;
  // Rotation order after last_grant, watchdog expiry and next-state decision
  always_comb begin
    first = last_grant == 2'd2 ? 2'd0 : last_grant + 2'd1;
    second = last_grant == 2'd0 ? 2'd2 : last_grant - 2'd1;
    sel = req_ena[first] ? first : req_ena[second] ? second : last_grant;
    expire = TIMEOUT != 0 && cnt == TLAST;
    start = state == IDLE && |req_ena;
    finish = state == WAIT && (sdram_done || expire);
    state_nx = start ? WAIT : finish ? HOLD : state == HOLD ? IDLE : state;
  end
  // State register
  always_ff @(posedge clk1x) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // Command capture at grant, completion handling and watchdog counter
  always_ff @(posedge clk1x) begin
    if (reset) begin
      last_grant <= 2'd2;
      grant <= '0;
      sdram_ena <= 1'b0;
      sdram_rnw <= 1'b0;
      sdram_Adr <= '0;
      sdram_be <= '0;
      sdram_dataWrite <= '0;
      req_done <= '0;
      req_dataRead <= '0;
      timeout_error <= 1'b0;
      cnt <= '0;
    end else begin
      sdram_ena <= 1'b0;
      req_done <= '0;
      if (start) begin
        grant <= sel;
        last_grant <= sel;
        sdram_ena <= 1'b1;
        sdram_rnw <= req_rnw[sel];
        sdram_Adr <= req_addr[sel*ADDR_W +: ADDR_W];
        sdram_be <= req_be[sel*BE_W +: BE_W];
        sdram_dataWrite <= req_dataWrite[sel*DATA_W +: DATA_W];
      end
      if (state == WAIT) cnt <= cnt + 1'b1;
      if (finish) begin
        req_done[grant] <= 1'b1;
        if (sdram_done && sdram_rnw) req_dataRead <= sdram_dataRead;
        if (!sdram_done) timeout_error <= 1'b1;
      end
      if (state == HOLD) cnt <= '0;
    end
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_sdram_ch1_arbiter.sv
// tb_sdram_ch1_arbiter: randomized scoreboard bench with transaction-level arbiter and controller models
module tb_sdram_ch1_arbiter;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int TO = 16;
  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic        terr;
    int          due;
  } exp_t;
  logic clk1x = 1'b0;
  logic reset = 1'b1;
  logic [2:0] ena = '0;
  logic [2:0] rnw_v = '0;
  logic [AW-1:0] addr_v[3];
  logic [3:0] be_v[3];
  logic [DW-1:0] wd_v[3];
  logic [2:0] req_ena, req_rnw, req_done;
  logic [3*AW-1:0] req_addr;
  logic [11:0] req_be;
  logic [3*DW-1:0] req_dataWrite;
  logic [DW-1:0] req_dataRead, sdram_dataWrite, sdram_dataRead;
  logic sdram_ena, sdram_rnw, sdram_done, busy, timeout_error;
  logic [AW-1:0] sdram_Adr;
  logic [3:0] sdram_be;
  logic [1:0] grant;
  logic ctl_done = 1'b0;
  logic spur_done = 1'b0;
  logic [31:0] ctl_rd = '0;
  logic [31:0] spur_rd = '0;
  logic [2:0] ena_at_edge = '0;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_last = 2;
  logic [31:0] m_rd = '0;
  logic m_terr = 1'b0;
  int ctl_mode = 0;
  int ctl_lat = 0;
  logic ctl_fix = 1'b0;
  logic [31:0] ctl_fix_data = '0;
  logic ctl_busy = 1'b0;

  assign req_ena = ena;
  assign req_rnw = rnw_v;
  assign req_addr = {addr_v[2], addr_v[1], addr_v[0]};
  assign req_be = {be_v[2], be_v[1], be_v[0]};
  assign req_dataWrite = {wd_v[2], wd_v[1], wd_v[0]};
  assign sdram_done = ctl_done | spur_done;
  assign sdram_dataRead = spur_done ? spur_rd : ctl_rd;

  sdram_ch1_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk1x(clk1x), .reset(reset),
    .req_ena(req_ena), .req_rnw(req_rnw), .req_addr(req_addr), .req_be(req_be),
    .req_dataWrite(req_dataWrite), .req_done(req_done), .req_dataRead(req_dataRead),
    .sdram_ena(sdram_ena), .sdram_rnw(sdram_rnw), .sdram_Adr(sdram_Adr), .sdram_be(sdram_be),
    .sdram_dataWrite(sdram_dataWrite), .sdram_done(sdram_done), .sdram_dataRead(sdram_dataRead),
    .busy(busy), .grant(grant), .timeout_error(timeout_error)
  );

  always #5 clk1x = ~clk1x;
  always @(posedge clk1x) cyc <= cyc + 1;
  always @(posedge clk1x) ena_at_edge <= req_ena;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rnd_op(input int i);
    rnw_v[i] = 1'($urandom);
    addr_v[i] = AW'($urandom);
    be_v[i] = 4'($urandom);
    wd_v[i] = $urandom;
  endtask

  // one clock of requester behaviour: drop after done, optionally raise a new request
  task automatic step(input int p_new, input logic [2:0] allow);
    logic [2:0] d;
    @(negedge clk1x);
    d = req_done;
    @(posedge clk1x);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (d[i]) ena[i] = 1'b0;
      else if (!ena[i] && allow[i] && $urandom_range(99) < p_new) begin
        rnd_op(i);
        ena[i] = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      step(0, 3'b000);
      t++;
    end while ((ena != 0 || exp_q.size() != 0 || busy || ctl_busy) && t < 200);
    n_chk++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL drain: requests still outstanding after %0d cycles, queue %0d", t, exp_q.size());
    end
  endtask

  // controller model: predicts the grant by rotation, checks the command, answers and queues the completion
  initial begin
    forever begin
      @(negedge clk1x);
      if (!reset && sdram_ena) begin
        int g, mode, lat;
        logic timed;
        logic [31:0] d;
        exp_t e;
        g = -1;
        for (int k = 1; k <= 3; k++)
          if (g < 0 && ena_at_edge[(m_last + k) % 3]) g = (m_last + k) % 3;
        if (g < 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL grant_without_request: sdram_ena with req_ena %b", ena_at_edge);
          g = int'(grant);
        end
        chk("grant", grant, g);
        chk("cmd", {sdram_rnw, sdram_Adr, sdram_be, sdram_dataWrite}, {rnw_v[g], addr_v[g], be_v[g], wd_v[g]});
        m_last = g;
        mode = ctl_mode == 4 ? ($urandom_range(7) == 0 ? 2 : 0) : ctl_mode;
        lat = mode == 3 ? TO : ctl_lat != 0 ? ctl_lat : int'($urandom_range(14, 1));
        timed = mode >= 2;
        d = ctl_fix ? ctl_fix_data : $urandom;
        if (!timed && rnw_v[g]) m_rd = d;
        if (timed) m_terr = 1'b1;
        e.idx = g;
        e.rd = m_rd;
        e.terr = m_terr;
        e.due = cyc + (timed ? TO : lat + 1);
        exp_q.push_back(e);
        if (mode != 2) begin
          ctl_busy = 1'b1;
          repeat (lat) @(posedge clk1x);
          #1;
          if (mode == 0)
            chk("cmd_stable", {sdram_rnw, sdram_Adr, sdram_be, sdram_dataWrite}, {rnw_v[g], addr_v[g], be_v[g], wd_v[g]});
          ctl_done = 1'b1;
          ctl_rd = d;
          @(posedge clk1x);
          #1;
          ctl_done = 1'b0;
          ctl_busy = 1'b0;
        end
      end
    end
  end

  // completion monitor
  always @(negedge clk1x) begin
    if (!reset) begin
      if (req_done != 0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_done: got req_done %b with nothing outstanding (cycle %0d)", req_done, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done", {req_done, req_dataRead, timeout_error, cyc}, {3'(1 << mon_e.idx), mon_e.rd, mon_e.terr, mon_e.due});
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_done: no req_done for requester %0d, due cycle %0d now %0d", exp_q[0].idx, exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = '0;
      be_v[i] = '0;
      wd_v[i] = '0;
    end
    repeat (3) @(posedge clk1x);
    @(negedge clk1x);
    chk("rst_busy", busy, 0);
    chk("rst_sdram_ena", sdram_ena, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_grant", grant, 0);
    chk("rst_timeout_error", timeout_error, 0);
    chk("rst_dataRead", req_dataRead, 0);
    @(posedge clk1x);
    #1 reset = 1'b0;
    @(posedge clk1x);
    #1;
    rnw_v[0] = 1'b1;
    addr_v[0] = 27'h100000;
    be_v[0] = 4'hf;
    wd_v[0] = '0;
    ctl_lat = 5;
    ctl_fix = 1'b1;
    ctl_fix_data = 32'hCAFEBABE;
    ena = 3'b001;
    @(negedge clk1x);
    chk("sdram_ena_cycle0", sdram_ena, 0);
    @(negedge clk1x);
    chk("sdram_ena_cycle1", {sdram_ena, sdram_Adr}, {1'b1, 27'h100000});
    drain();
    ctl_fix = 1'b0;
    ctl_lat = 0;
    chk("read_data", req_dataRead, 32'hCAFEBABE);
    rnw_v[1] = 1'b0;
    addr_v[1] = 27'h0800000;
    be_v[1] = 4'b0101;
    wd_v[1] = 32'h11223344;
    ena = 3'b010;
    drain();
    chk("write_keeps_dataRead", req_dataRead, 32'hCAFEBABE);
    spur_rd = 32'hDEAD0001;
    spur_done = 1'b1;
    @(posedge clk1x);
    #1 spur_done = 1'b0;
    @(negedge clk1x);
    chk("idle_done_ignored", {req_done, req_dataRead}, {3'b000, 32'hCAFEBABE});
    @(posedge clk1x);
    #1;
    ctl_lat = TO - 1;
    rnd_op(2);
    rnw_v[2] = 1'b1;
    ena = 3'b100;
    drain();
    ctl_lat = 0;
    chk("coincident_no_timeout_error", timeout_error, 0);
    repeat (80) step(100, 3'b111);
    drain();
    ctl_mode = 2;
    rnd_op(0);
    ena = 3'b001;
    drain();
    chk("timeout_error_set", timeout_error, 1);
    ctl_mode = 3;
    rnd_op(1);
    ena = 3'b010;
    drain();
    ctl_mode = 0;
    rnd_op(2);
    ena = 3'b100;
    drain();
    chk("timeout_error_sticky", timeout_error, 1);
    ctl_mode = 4;
    repeat (400) step(30, 3'b111);
    ctl_mode = 0;
    drain();
    ctl_mode = 2;
    rnd_op(1);
    ena = 3'b010;
    t = 0;
    do begin
      @(negedge clk1x);
      t++;
    end while (!sdram_ena && t < 10);
    if (!sdram_ena) begin
      n_chk++;
      n_fail++;
      $display("FAIL reset_test_grant: sdram_ena never rose");
    end
    @(posedge clk1x);
    #1;
    reset = 1'b1;
    ena = 3'b000;
    @(posedge clk1x);
    @(negedge clk1x);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_sdram_ena", sdram_ena, 0);
    chk("rst_mid_req_done", req_done, 0);
    chk("rst_mid_grant", grant, 0);
    @(posedge clk1x);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_last = 2;
    m_rd = '0;
    m_terr = 1'b0;
    ctl_mode = 0;
    for (int i = 0; i < 3; i++) rnd_op(i);
    ena = 3'b111;
    drain();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_ch1_arbiter.md
Name: sdram_ch1_arbiter

Overview:
- Shares the single SDRAM channel 1 port (27-bit address, 32-bit data, req/ready handshake) between three N64 requesters: 0 = PI cart ROM read, 1 = SRAM/FLASH save access, 2 = savestate engine.
- Sits between n64top-side clients and the sdram controller in the clk1x domain.
- Round-robin grant, one outstanding transaction at a time.
- Watchdog prevents a lost ready from hanging the system.

Parameters:
- ADDR_W, 27, SDRAM byte address width.
- DATA_W, 32, data width; byte enables are DATA_W/8.
- TIMEOUT, 4095, cycles to wait for sdram_done before forced completion; 0 disables the watchdog.

Ports:
- clk1x  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_ena  in  3  per-requester request level; held until the matching req_done.
- req_rnw  in  3  per-requester: 1 = read, 0 = write.
- req_addr  in  3*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_be  in  3*4  packed byte enables.
- req_dataWrite  in  3*DATA_W  packed write data.
- req_done  out  3  one-cycle completion pulse per requester.
- req_dataRead  out  DATA_W  read data from the last completed read, shared by all requesters.
- sdram_ena  out  1  one-cycle request pulse to the controller.
- sdram_rnw  out  1  direction for sdram_ena.
- sdram_Adr  out  ADDR_W  address.
- sdram_be  out  4  byte enables.
- sdram_dataWrite  out  DATA_W  write data.
- sdram_done  in  1  controller ready pulse.
- sdram_dataRead  in  DATA_W  controller read data, valid with sdram_done.
- busy  out  1  high while the state is not IDLE.
- grant  out  2  index of the current or last granted requester.
- timeout_error  out  1  sticky; set on watchdog expiry, cleared only by reset.

Behaviour:
- Reset values: state IDLE; last_grant = 2 (so requester 0 has top priority first); all outputs 0; timeout counter 0.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - If any req_ena bit is set, select the first set bit searching (last_grant+1) mod 3, then +2 mod 3, then last_grant.
  - Register grant/last_grant, sdram_rnw, sdram_Adr, sdram_be, sdram_dataWrite from that requester.
  - Set sdram_ena = 1 for exactly one cycle. Go to WAIT.
  - With no requests, stay in IDLE.
- WAIT:
  - sdram_ena = 0; sdram_* address/data/be/rnw held stable.
  - Timeout counter increments each cycle.
  - On sdram_done: if rnw, latch sdram_dataRead into req_dataRead; pulse req_done[grant]; go to HOLD.
  - On counter reaching TIMEOUT (TIMEOUT≠0) without done: pulse req_done[grant], leave req_dataRead unchanged, set timeout_error, go to HOLD.
  - Done and timeout in the same cycle count as done; timeout_error is not set.
- HOLD:
  - One cycle in which req_done is high. The requester clears req_ena at the following edge.
  - Clear the timeout counter; go to IDLE.
  - No new grant is evaluated in HOLD, so a completed requester is never re-granted on a stale level.
- Latency:
  - req_ena rises in cycle 0 (arbiter in IDLE) → sdram_ena in cycle 1.
  - sdram_done in cycle k → req_done and req_dataRead valid in cycle k+1.
  - Minimum request-to-request spacing is 3 cycles plus controller latency.
- Writes: req_dataRead is unchanged.
- Reads: req_dataRead holds until the next completed read.
- sdram_done received in IDLE or HOLD is ignored: no req_done, no data latch.
  - A controller ready that arrives late after a watchdog expiry is therefore dropped only if it lands outside WAIT; software treats timeout_error as fatal.
- Input stability: a requester dropping req_ena while granted does not abort the transaction; req_done is still issued. Inputs of the granted requester are sampled only in the IDLE grant cycle.
- Reset mid-transaction: immediate return to IDLE with all outputs cleared. The sdram controller shares the same reset, so no drain is needed.
- Simultaneous requests are served strictly in rotation; a continuously requesting client waits at most 2 transactions.

Test Plan:
- Single read: after reset, req_ena=001, addr=0x100000, rnw=1; controller returns 0xCAFEBABE 5 cycles after sdram_ena → sdram_ena in cycle 1 with Adr 0x100000; req_done=001 and req_dataRead=0xCAFEBABE one cycle after sdram_done.
- Round-robin: all three requesters hold req_ena continuously, re-asserting one cycle after each done → grant sequence 0,1,2,0,1,2; never two consecutive grants to the same requester.
- Write with be: requester 1 writes 0x11223344, be=0101, at 0x0800000 → sdram_rnw=0, be=0101, data matches; req_dataRead keeps the previous read value after done.
- Watchdog: TIMEOUT=16, controller never answers → req_done for the granted requester exactly 16 cycles after entering WAIT; timeout_error=1 and stays set; the next request proceeds normally.
- Spurious/coincident events: sdram_done pulsed in IDLE → no req_done. sdram_done on the same cycle as timeout expiry → done path taken, timeout_error stays 0.
- Reset mid-WAIT: assert reset in the 2nd WAIT cycle → next cycle busy=0, sdram_ena=0, req_done=000, grant=0; the first request after reset goes to requester 0 when all three request.
